// File: rtl/bp_choice_ctrl.sv
// bp_choice_ctrl: chooser-table port scheduler (clear, lookups, queued RMW updates); optional forwarding via BP_CHOICE_BYPASS_EN
module bp_choice_ctrl #(
  parameter int IDX_W        = 10,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_p1_ok,
  input  logic             res_p2_ok,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_choice,
  output logic             lk_choice_valid,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata,
  output logic             init_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
  state_t           r_state, w_state_n;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_fidx [DEPTH];
  logic [1:0]       r_fok  [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_occ, w_occ_n;
  logic             r_ready;
  logic [SW-1:0]    r_starve;
  logic [1:0]       r_cnt_q;
  logic             r_lk_v;
  logic             w_push, w_pop, w_lk_grant, w_blocked, w_starved, w_nonempty, w_head_upd;
  logic [IDX_W-1:0] w_head_idx;
  logic [1:0]       w_head_ok, w_next;
  assign w_push     = res_valid && r_ready;
  assign w_nonempty = r_occ != '0;
  assign w_head_idx = r_fidx[r_rp];
  assign w_head_ok  = r_fok[r_rp];
  assign w_head_upd = w_nonempty && (w_head_ok[1] != w_head_ok[0]);
  assign w_starved  = r_starve >= SW'(STARVE_LIMIT);
  assign w_occ_n    = r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_next     = (w_head_ok == 2'b01) ? ((&tbl_rdata) ? tbl_rdata : tbl_rdata + 2'd1) :
                      (w_head_ok == 2'b10) ? ((|tbl_rdata) ? tbl_rdata - 2'd1 : tbl_rdata) : tbl_rdata;
  assign res_ready  = r_ready;
  assign init_busy  = r_state == INIT;
  assign lk_choice_valid = r_lk_v;
  // Next state, table port drive and lookup grant; lookups win unless the head has starved
  always_comb begin
    w_state_n  = r_state;
    w_pop      = 1'b0;
    w_lk_grant = 1'b0;
    w_blocked  = 1'b0;
    tbl_en     = 1'b0;
    tbl_we     = 1'b0;
    tbl_addr   = '0;
    tbl_wdata  = 2'b00;
    case (r_state)
      INIT: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = r_ptr;
        w_state_n = (&r_ptr) ? IDLE : INIT;
      end
      IDLE: begin
        if (w_head_upd && (!lk_valid || w_starved)) begin
          tbl_en    = 1'b1;
          tbl_addr  = w_head_idx;
          w_state_n = READ;
        end else begin
          w_lk_grant = lk_valid;
          w_blocked  = w_head_upd;
          w_pop      = w_nonempty && !w_head_upd;
        end
      end
      READ: begin
        w_lk_grant = lk_valid;
        w_state_n  = WRITE;
      end
      WRITE: begin
        if (lk_valid && !w_starved) begin
          w_lk_grant = 1'b1;
          w_blocked  = 1'b1;
        end else begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = w_head_idx;
          tbl_wdata = r_cnt_q;
          w_pop     = 1'b1;
          w_state_n = IDLE;
        end
      end
    endcase
    if (w_lk_grant) begin
      tbl_en   = 1'b1;
      tbl_addr = lk_idx;
    end
    if (rst) begin
      tbl_en     = 1'b0;
      tbl_we     = 1'b0;
      tbl_addr   = '0;
      tbl_wdata  = 2'b00;
      w_lk_grant = 1'b0;
    end
  end
  // State, clear pointer, FIFO pointers/occupancy, registered ready, starve count, lookup response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= INIT;
      r_ptr    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_occ    <= '0;
      r_ready  <= 1'b0;
      r_starve <= '0;
      r_lk_v   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_ptr    <= (r_state == INIT) ? r_ptr + 1'b1 : r_ptr;
      r_wp     <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp     <= w_pop ? r_rp + 1'b1 : r_rp;
      r_occ    <= w_occ_n;
      r_ready  <= (w_state_n != INIT) && (w_occ_n != (AW+1)'(DEPTH));
      r_starve <= w_pop ? '0 : (w_blocked && !w_starved) ? r_starve + SW'(1) : r_starve;
      r_lk_v   <= w_lk_grant;
    end
  end
  // FIFO payload and the counter value computed in READ; no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fidx[r_wp] <= res_idx;
      r_fok[r_wp]  <= {res_p1_ok, res_p2_ok};
    end
    if (r_state == READ) r_cnt_q <= w_next;
  end
`ifdef BP_CHOICE_BYPASS_EN
  logic r_byp, r_byp_v;
  // Forward the in-flight updated counter to a lookup that hits the head index
  always_ff @(posedge clk) begin
    r_byp_v <= !rst && w_lk_grant && (r_state == READ || r_state == WRITE) && (lk_idx == w_head_idx);
    r_byp   <= (r_state == READ) ? w_next[1] : r_cnt_q[1];
  end
  assign lk_choice = r_lk_v && (r_byp_v ? r_byp : tbl_rdata[1]);
`else
  assign lk_choice = r_lk_v && tbl_rdata[1];
`endif
endmodule
